// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access stage.
// Holds funct3 size codes, FSM states and the default timeout.
package mem_access_unit_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage and the memory port.
// The MEM stage is the master; the memory answers with ack/rdata.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a load word and extends it.
// Purely combinational.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'd0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'd0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues one data-memory access per instruction,
// stalling the pipe until ack or timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_RW,
  input  logic        ex_MR,
  input  logic        ex_MW,
  input  logic [2:0]  ex_funct3,
  mem_access_unit_if.master dmem,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_read_data,
  output logic [4:0]  mem_rd,
  output logic        mem_RW,
  output logic        mem_MR,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            bus_err_q, bus_err_d;

  logic [1:0]  sz, off;
  logic        is_mem, bad_f3, mis;
  logic        illegal, legal;
  logic        stall, mis_err;
  logic [31:0] fmt;

  assign sz  = ex_funct3[1:0];
  assign off = ex_alu_result[1:0];

  always_comb begin
    is_mem  = ex_MR | ex_MW;
    bad_f3  = (sz == 2'd3) || (ex_funct3 == 3'b110);
    mis     = ((sz == SZ_H) && off[0]) ||
              ((sz == SZ_W) && (off != 2'd0));
    illegal = ex_valid && is_mem &&
              (bad_f3 || mis || (ex_MR && ex_MW));
    legal   = ex_valid && is_mem && !illegal;
  end

  load_formatter u_fmt (
    .rdata  (dmem.dmem_rdata),
    .off    (off),
    .funct3 (ex_funct3),
    .data   (fmt)
  );

  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = ex_store_data;
    unique case (sz)
      SZ_B: begin
        dmem.dmem_be    = 4'b0001 << off;
        dmem.dmem_wdata = {4{ex_store_data[7:0]}};
      end
      SZ_H: begin
        dmem.dmem_be    = 4'b0011 << {off[1], 1'b0};
        dmem.dmem_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    bus_err_d    = 1'b0;
    stall        = 1'b0;
    mis_err      = 1'b0;
    mem_RW       = 1'b0;
    dmem.dmem_req = 1'b0;
    dmem.dmem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mis_err = illegal;
        mem_RW  = ex_valid && !is_mem && ex_RW;
        if (legal) begin
          stall   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall         = 1'b1;
        dmem.dmem_req = 1'b1;
        dmem.dmem_we  = ex_MW;
        if (dmem.dmem_ack) begin
          rdata_d = ex_MR ? fmt : 32'd0;
          state_d = DONE;
        end else if (cnt_q == LAST) begin
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        mem_RW  = ex_RW && !bus_err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // IDLE-state decode is combinational, so reset must mask it too
  assign mem_stall      = stall & rst;
  assign misalign_err   = mis_err & rst;
  assign bus_err        = bus_err_q;
  assign mem_read_data  = rdata_q;
  assign mem_alu_result = ex_alu_result;
  assign mem_rd         = ex_rd;
  assign mem_MR         = ex_MR;
  assign dmem.dmem_addr = {ex_alu_result[31:2], 2'b00};

endmodule
